// File: rtl/ctech_lib_preset_seq.sv
// Preset sequencer: holds NGRP active-low async-set lines low after reset or on
// request, then releases them one group at a time to spread the set-deassert load.
module ctech_lib_preset_seq #(
  parameter int NGRP = 4,
  parameter int HOLD = 3,
  parameter int GAP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            preset_req,
  output logic            preset_ack,
  output logic            busy,
  output logic            done,
  output logic [NGRP-1:0] setb_o
);

  // state      | meaning
  // ST_SYNC    | waiting for the synchronized reset to deassert
  // ST_HOLD    | all groups held in preset, counting HOLD cycles
  // ST_RELEASE | releasing groups in index order, GAP+1 cycles apart
  // ST_IDLE    | all groups released; accepts a software re-preset request
  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_RELEASE,
    ST_IDLE
  } state_t;

  localparam int HW = $clog2(HOLD + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int IW = (NGRP > 1) ? $clog2(NGRP) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP);
  localparam logic [IW-1:0] GRP_LAST  = IW'(NGRP - 1);

  logic            rst_meta_q, rst_meta_d;
  logic            rst_sync_q, rst_sync_d;
  logic            rst_release;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   grp_q, grp_d;
  logic [IW-1:0]   grp_next;
  logic [NGRP-1:0] setb_q, setb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            req_flag_q, req_flag_d;

  // Two-stage reset synchronizer; the internal reset drops on the edge where
  // the second stage clears, and that same edge starts the hold count.
  always_comb begin
    rst_meta_d  = 1'b0;
    rst_sync_d  = rst_meta_q;
    rst_release = rst_sync_q & ~rst_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    grp_d      = grp_q;
    setb_d     = setb_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ack_d      = 1'b0;
    req_flag_d = req_flag_q;
    grp_next   = grp_q + IW'(1);

    case (state_q)
      ST_SYNC: begin
        setb_d     = '0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        req_flag_d = 1'b0;
        if (rst_release) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end

      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d   = ST_RELEASE;
          grp_d     = '0;
          gap_d     = '0;
          setb_d[0] = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      ST_RELEASE: begin
        if (grp_q == GRP_LAST) begin
          // Completion lands one edge after the last release regardless of GAP.
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          ack_d      = req_flag_q;
          req_flag_d = 1'b0;
        end else if (gap_q == GAP_LAST) begin
          grp_d = grp_next;
          gap_d = '0;
          for (int k = 0; k < NGRP; k++) begin
            if (IW'(k) == grp_next) setb_d[k] = 1'b1;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      ST_IDLE: begin
        if (preset_req) begin
          state_d    = ST_HOLD;
          hold_d     = '0;
          setb_d     = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          req_flag_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_SYNC;
        setb_d  = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      hold_q     <= '0;
      gap_q      <= '0;
      grp_q      <= '0;
      setb_q     <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      req_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      grp_q      <= grp_d;
      setb_q     <= setb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      req_flag_q <= req_flag_d;
    end
  end

  assign setb_o     = setb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign preset_ack = ack_q;

endmodule

// File: tb/tb_ctech_lib_preset_seq.sv
// Scoreboard bench: three sequencer instances (default, NGRP=1/HOLD=1/GAP=0,
// NGRP=16/GAP=0) checked cycle by cycle against the release-schedule formula.
module tb_ctech_lib_preset_seq;

  localparam int NP[3] = '{4, 1, 16};
  localparam int HP[3] = '{3, 1, 3};
  localparam int GP[3] = '{1, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;

  logic        ack0, busy0, done0;
  logic        ack1, busy1, done1;
  logic        ack2, busy2, done2;
  logic [3:0]  setb0;
  logic [0:0]  setb1;
  logic [15:0] setb2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] setb;
    logic        busy;
    logic        done;
    logic        ack;
  } exp_t;

  exp_t sb[$];

  ctech_lib_preset_seq #(.NGRP(4), .HOLD(3), .GAP(1)) u_dut0 (
    .clk(clk), .rst(rst), .preset_req(req[0]), .preset_ack(ack0),
    .busy(busy0), .done(done0), .setb_o(setb0)
  );

  ctech_lib_preset_seq #(.NGRP(1), .HOLD(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst(rst), .preset_req(req[1]), .preset_ack(ack1),
    .busy(busy1), .done(done1), .setb_o(setb1)
  );

  ctech_lib_preset_seq #(.NGRP(16), .HOLD(3), .GAP(0)) u_dut2 (
    .clk(clk), .rst(rst), .preset_req(req[2]), .preset_ack(ack2),
    .busy(busy2), .done(done2), .setb_o(setb2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] get_obs(input int id);
    logic [18:0] o;
    case (id)
      0:       o = {12'b0, setb0, busy0, done0, ack0};
      1:       o = {15'b0, setb1, busy1, done1, ack1};
      default: o = {setb2, busy2, done2, ack2};
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected outputs for every cycle of one sequence starting at e0, plus tail idle cycles.
  task automatic push_seq(input int id, input int e0, input bit req_init, input int tail);
    int   edone;
    exp_t e;
    edone = e0 + HP[id] + (NP[id] - 1) * (GP[id] + 1) + 1;
    for (int c = e0; c <= edone + tail; c++) begin
      e.cyc  = c;
      e.id   = id;
      e.setb = '0;
      for (int k = 0; k < NP[id]; k++)
        e.setb[k] = (c >= e0 + HP[id] + k * (GP[id] + 1));
      e.busy = (c < edone);
      e.done = (c >= edone);
      e.ack  = req_init && (c == edone);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk($sformatf("seq id=%0d cyc=%0d", sb[i].id, cyc), get_obs(sb[i].id),
            {sb[i].setb, sb[i].busy, sb[i].done, sb[i].ack});
        sb.delete(i);
      end
    end
  end

  initial begin
    int t;
    int e0;

    #1 rst = 1'b1;
    #1;
    for (int id = 0; id < 3; id++)
      chk($sformatf("reset id=%0d", id), get_obs(id), {16'b0, 1'b1, 1'b0, 1'b0});

    // Power-up: release rst between edges, E0 is the second edge after.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e0  = cyc + 2;
    for (int id = 0; id < 3; id++) push_seq(id, e0, 1'b0, 1);
    repeat (25) @(negedge clk);

    // Single-cycle software request on all instances.
    req = 3'b111;
    t   = cyc + 1;
    for (int id = 0; id < 3; id++) push_seq(id, t, 1'b1, 1);
    @(negedge clk);
    req = 3'b000;
    repeat (22) @(negedge clk);

    // Request held through the whole sequence, dropped in the ack cycle.
    req[0] = 1'b1;
    t      = cyc + 1;
    push_seq(0, t, 1'b1, 4);
    while (cyc < t + 10) @(negedge clk);
    req[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Request still high after ack: a second sequence starts right after.
    req[0] = 1'b1;
    t      = cyc + 1;
    push_seq(0, t, 1'b1, 0);
    push_seq(0, t + 11, 1'b1, 3);
    while (cyc < t + 21) @(negedge clk);
    req[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Short reset pulse in the middle of a software sequence.
    req[0] = 1'b1;
    t      = cyc + 1;
    push_seq(0, t, 1'b1, 5);
    @(negedge clk);
    req[0] = 1'b0;
    while (cyc < t + 5) @(negedge clk);
    #1;
    chk("mid_seq_setb", {15'b0, setb0}, {15'b0, 4'b0011});
    rst = 1'b1;
    #1;
    for (int id = 0; id < 3; id++)
      chk($sformatf("mid_reset id=%0d", id), get_obs(id), {16'b0, 1'b1, 1'b0, 1'b0});
    sb.delete();
    #1 rst = 1'b0;
    e0 = cyc + 2;
    for (int id = 0; id < 3; id++) push_seq(id, e0, 1'b0, 2);
    repeat (26) @(negedge clk);

    chk("scoreboard_drained", 19'(sb.size()), 19'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
